// File: rtl/lcd_id_cfg_if.sv
// LCD panel-ID / configuration bus.
// Groups the pad-side strap inputs, the redetect request and the
// configuration handed to the LCD timing/driver logic.
//   lcd_rgb   : pad input data (bit4=M2, bit10=M1, bit15=M0)
//   redetect  : single-cycle request to re-run detection
//   rgb_oe    : 1 = driver may drive the pads, 0 = pads released
//   lcd_id    : detected panel ID
//   h_disp    : active pixels per line
//   v_disp    : active lines per frame
//   pclk_sel  : pixel-clock select code
//   cfg_valid : configuration valid and stable
//   id_err    : detection failed or unknown code
interface lcd_id_cfg_if;
  logic [15:0] lcd_rgb;
  logic        redetect;
  logic        rgb_oe;
  logic [15:0] lcd_id;
  logic [10:0] h_disp;
  logic [10:0] v_disp;
  logic [1:0]  pclk_sel;
  logic        cfg_valid;
  logic        id_err;

  // master: top level / pads / timing generator side
  modport master (
    output lcd_rgb, redetect,
    input  rgb_oe, lcd_id, h_disp, v_disp, pclk_sel, cfg_valid, id_err
  );

  // slave: the detection controller
  modport slave (
    input  lcd_rgb, redetect,
    output rgb_oe, lcd_id, h_disp, v_disp, pclk_sel, cfg_valid, id_err
  );
endinterface

// File: rtl/lcd_id_cfg_ctrl.sv
// Panel-ID detection controller for the RGB LCD data bus.
// Releases the pads, waits SETTLE_CYC cycles for the straps to settle,
// debounces the 3-bit strap code (STABLE_NUM identical samples, at most
// MAX_TRY mismatches), maps it to a panel configuration and holds it
// valid until a redetect request.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : lcd_id_cfg_if slave (strap inputs, redetect, configuration)
module lcd_id_cfg_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int STABLE_NUM = 4,
  parameter int MAX_TRY    = 8
) (
  input  logic         clk,
  input  logic         rst,
  lcd_id_cfg_if.slave  bus
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int NW = $clog2(STABLE_NUM + 1);
  localparam int TW = $clog2(MAX_TRY + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [NW-1:0] STABLE_LAST = NW'(STABLE_NUM - 1);
  localparam logic [TW-1:0] TRY_LAST    = TW'(MAX_TRY - 1);

  typedef enum logic [2:0] {
    IDLE, RELEASE, SAMPLE, LOOKUP, FAIL, DONE
  } state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [10:0] h;
    logic [10:0] v;
    logic [1:0]  pclk;
    logic        err;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{id: 16'h0000, h: 11'd480, v: 11'd272,
                               pclk: 2'd0, err: 1'b0};

  // Panel IDs are the part numbers written as hex digits.
  function automatic cfg_t cfg_lookup(input logic [2:0] c);
    cfg_t r;
    r = DEF_CFG;
    case (c)
      3'b000:  r = '{id: 16'h4342, h: 11'd480,  v: 11'd272, pclk: 2'd0, err: 1'b0};
      3'b001:  r = '{id: 16'h7084, h: 11'd800,  v: 11'd480, pclk: 2'd2, err: 1'b0};
      3'b010:  r = '{id: 16'h7016, h: 11'd1024, v: 11'd600, pclk: 2'd3, err: 1'b0};
      3'b100:  r = '{id: 16'h4384, h: 11'd800,  v: 11'd480, pclk: 2'd1, err: 1'b0};
      3'b101:  r = '{id: 16'h1018, h: 11'd1280, v: 11'd800, pclk: 2'd3, err: 1'b0};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [NW-1:0] stable_cnt_q, stable_cnt_d;
  logic [TW-1:0] try_cnt_q, try_cnt_d;
  logic [2:0]    ref_q, ref_d;
  cfg_t          cfg_q, cfg_d;
  logic [2:0]    code;

  assign code = {bus.lcd_rgb[4], bus.lcd_rgb[10], bus.lcd_rgb[15]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      stable_cnt_q <= '0;
      try_cnt_q    <= '0;
      ref_q        <= '0;
      cfg_q        <= DEF_CFG;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      try_cnt_q    <= try_cnt_d;
      ref_q        <= ref_d;
      cfg_q        <= cfg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    stable_cnt_d = stable_cnt_q;
    try_cnt_d    = try_cnt_q;
    ref_d        = ref_q;
    cfg_d        = cfg_q;
    case (state_q)
      IDLE: begin
        settle_cnt_d = '0;
        stable_cnt_d = '0;
        try_cnt_d    = '0;
        state_d      = RELEASE;
      end
      RELEASE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        // stable_cnt==0 only on the first SAMPLE cycle
        if (stable_cnt_q == '0) begin
          ref_d        = code;
          stable_cnt_d = NW'(1);
        end else if (code == ref_q) begin
          stable_cnt_d = stable_cnt_q + 1'b1;
          if (stable_cnt_q == STABLE_LAST) begin
            state_d = LOOKUP;
          end
        end else if (try_cnt_q == TRY_LAST) begin
          state_d = FAIL;
        end else begin
          ref_d        = code;
          stable_cnt_d = NW'(1);
          try_cnt_d    = try_cnt_q + 1'b1;
        end
      end
      LOOKUP: begin
        cfg_d   = cfg_lookup(ref_q);
        state_d = DONE;
      end
      FAIL: begin
        cfg_d     = DEF_CFG;
        cfg_d.err = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        // Only the error flag drops; the last configuration is held.
        if (bus.redetect) begin
          settle_cnt_d = '0;
          stable_cnt_d = '0;
          try_cnt_d    = '0;
          cfg_d.err    = 1'b0;
          state_d      = RELEASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rgb_oe    = (state_q == DONE);
  assign bus.cfg_valid = (state_q == DONE);
  assign bus.lcd_id    = cfg_q.id;
  assign bus.h_disp    = cfg_q.h;
  assign bus.v_disp    = cfg_q.v;
  assign bus.pclk_sel  = cfg_q.pclk;
  assign bus.id_err    = cfg_q.err;

endmodule

// File: tb/tb_lcd_id_cfg_ctrl.sv
module tb_lcd_id_cfg_ctrl;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  lcd_id_cfg_if bus ();

  lcd_id_cfg_ctrl #(
    .SETTLE_CYC (16),
    .STABLE_NUM (4),
    .MAX_TRY    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_cfg(input string tag, input logic [15:0] id, input logic [10:0] h,
                         input logic [10:0] v, input logic [1:0] p, input logic err,
                         input logic valid);
    chk({tag, ".lcd_id"},    32'(bus.lcd_id),    32'(id));
    chk({tag, ".h_disp"},    32'(bus.h_disp),    32'(h));
    chk({tag, ".v_disp"},    32'(bus.v_disp),    32'(v));
    chk({tag, ".pclk_sel"},  32'(bus.pclk_sel),  32'(p));
    chk({tag, ".id_err"},    32'(bus.id_err),    32'(err));
    chk({tag, ".cfg_valid"}, 32'(bus.cfg_valid), 32'(valid));
    chk({tag, ".rgb_oe"},    32'(bus.rgb_oe),    32'(valid));
  endtask

  // One rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  // Non-strap pad bits get random values so only bits 4/10/15 matter.
  task automatic set_code(input logic [2:0] c);
    logic [15:0] r;
    r = 16'($urandom);
    r[4]  = c[2];
    r[10] = c[1];
    r[15] = c[0];
    bus.lcd_rgb = r;
  endtask

  task automatic pulse_redetect();
    bus.redetect = 1'b1;
    step();
    bus.redetect = 1'b0;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    rst          = 1'b1;
    bus.redetect = 1'b0;
    set_code(3'b001);
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk_cfg("reset", 16'h0000, 11'd480, 11'd272, 2'd0, 1'b0, 1'b0);

    // Code 001 held: cfg_valid rises on edge 22
    rst = 1'b0;
    cycles(21);
    chk("c001.valid_e21", 32'(bus.cfg_valid), 32'd0);
    step();
    chk_cfg("c001", 16'h7084, 11'd800, 11'd480, 2'd2, 1'b0, 1'b1);

    // Code 101 via redetect: drop next cycle, config held, valid 21 edges later
    set_code(3'b101);
    pulse_redetect();
    chk_cfg("c101.drop", 16'h7084, 11'd800, 11'd480, 2'd2, 1'b0, 1'b0);
    cycles(20);
    chk("c101.valid_e20", 32'(bus.cfg_valid), 32'd0);
    step();
    chk_cfg("c101", 16'h1018, 11'd1280, 11'd800, 2'd3, 1'b0, 1'b1);

    // Code 110: unknown -> error config, still valid
    set_code(3'b110);
    pulse_redetect();
    cycles(21);
    chk_cfg("c110", 16'h0000, 11'd480, 11'd272, 2'd0, 1'b1, 1'b1);

    // id_err clears in RELEASE; RELEASE codes ignored; SAMPLE toggles -> FAIL
    set_code(3'b000);
    pulse_redetect();
    chk("tog.err_cleared", 32'(bus.id_err), 32'd0);
    for (int k = 1; k <= 25; k++) begin
      if (k <= 16)                set_code(3'($urandom));
      else if (((k - 17) % 2) == 0) set_code(3'b000);
      else                        set_code(3'b100);
      step();
    end
    chk("tog.valid_e25", 32'(bus.cfg_valid), 32'd0);
    step();
    chk_cfg("tog.fail", 16'h0000, 11'd480, 11'd272, 2'd0, 1'b1, 1'b1);

    // One-cycle glitch mid-SAMPLE restarts the stable count
    set_code(3'b100);
    pulse_redetect();
    for (int k = 1; k <= 23; k++) begin
      if (k == 19) set_code(3'b000);
      else         set_code(3'b100);
      step();
    end
    chk("glitch.valid_e23", 32'(bus.cfg_valid), 32'd0);
    step();
    chk_cfg("glitch", 16'h4384, 11'd800, 11'd480, 2'd1, 1'b0, 1'b1);

    // Code 000 with a redetect pulse during SAMPLE (ignored)
    set_code(3'b000);
    pulse_redetect();
    cycles(16);
    pulse_redetect();
    cycles(3);
    chk("c000.valid_e20", 32'(bus.cfg_valid), 32'd0);
    step();
    chk_cfg("c000", 16'h4342, 11'd480, 11'd272, 2'd0, 1'b0, 1'b1);
    cycles(3);
    chk("c000.hold", 32'(bus.cfg_valid), 32'd1);

    // From 4342, pins to 010 and redetect
    set_code(3'b010);
    pulse_redetect();
    chk_cfg("c010.drop", 16'h4342, 11'd480, 11'd272, 2'd0, 1'b0, 1'b0);
    cycles(21);
    chk_cfg("c010", 16'h7016, 11'd1024, 11'd600, 2'd3, 1'b0, 1'b1);

    // Asynchronous reset mid-SAMPLE
    set_code(3'b001);
    pulse_redetect();
    cycles(18);
    #2 rst = 1'b1;
    #1;
    chk_cfg("rst_sample", 16'h0000, 11'd480, 11'd272, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycles(21);
    chk("rst_sample.valid_e21", 32'(bus.cfg_valid), 32'd0);
    step();
    chk_cfg("rst_sample.redo", 16'h7084, 11'd800, 11'd480, 2'd2, 1'b0, 1'b1);

    // Asynchronous reset mid-DONE, then unknown code 111
    #2 rst = 1'b1;
    #1;
    chk_cfg("rst_done", 16'h0000, 11'd480, 11'd272, 2'd0, 1'b0, 1'b0);
    set_code(3'b111);
    @(negedge clk);
    rst = 1'b0;
    cycles(22);
    chk_cfg("c111", 16'h0000, 11'd480, 11'd272, 2'd0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
